// File: rtl/rom_ctrl_pkg.sv
// Shared types and constants for the program-ROM fetch controller and its helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rom_ctrl_pkg;

  localparam int ROM_ADDR_W = 12;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_NIB_W  = ROM_DATA_W / 2;

  // Sequencer states; encoding is fixed so other labs can decode it.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_t;

  typedef struct packed {
    logic [ROM_NIB_W-1:0] instr;
    logic [ROM_NIB_W-1:0] oprnd;
  } nib_pair_t;

  // Split a ROM word into instruction (upper) and operand (lower) nibbles.
  function automatic nib_pair_t split_nibbles(input logic [ROM_DATA_W-1:0] word);
    nib_pair_t p;
    p.instr = word[ROM_DATA_W-1:ROM_NIB_W];
    p.oprnd = word[ROM_NIB_W-1:0];
    return p;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter with absolute load and wrap-around increment.
// Latency: new value visible one clock after load/inc is sampled.
// Backpressure: none; holds its value whenever neither load nor inc is asserted.
module program_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  // Load takes priority over increment; increment wraps silently at the top of the space.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Fetch sequencer: drives ROM address from the PC, captures one byte every two cycles as instr/oprnd nibbles.
// Latency: byte at pc is captured on the edge ending the FETCH cycle; outputs are all registered.
// Backpressure: en=0 freezes the sequence (state drops to IDLE, pc and captured data held); load overrides en.
module rom_fetch_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic                phase,
  output logic                valid
);

  localparam int NIB_W = DATA_W / 2;

  state_t state;
  state_t state_nxt;
  logic   capture;

  program_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .inc       (capture),
    .load      (load),
    .load_addr (load_addr),
    .pc        (pc)
  );

  // ROM address is a straight copy of the PC so the async ROM settles within the FETCH cycle.
  assign rom_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and capture decision; load pre-empts any capture in the same cycle.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (load) begin
      state_nxt = en ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) state_nxt = S_FETCH;
        end
        S_FETCH: begin
          if (en) begin
            capture   = 1'b1;
            state_nxt = S_EXEC;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_EXEC: begin
          state_nxt = en ? S_FETCH : S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Nibble capture, valid tracking and registered phase decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
      oprnd <= '0;
      valid <= 1'b0;
      phase <= 1'b0;
    end else begin
      phase <= (state_nxt == S_EXEC);
      if (load) begin
        valid <= 1'b0;
      end else if (capture) begin
        instr <= rom_data[DATA_W-1:NIB_W];
        oprnd <= rom_data[NIB_W-1:0];
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: directed scenarios then randomized traffic against a behavioural model.
// Latency: model predicts outputs after every rising edge; outputs sampled 1 time unit after the edge.
// Backpressure: en/load are randomized to exercise pause, resume and jump paths.
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        load;
  logic [11:0] load_addr;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] pc;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic        phase;
  logic        valid;

  logic [7:0] rom [4096];

  int errors = 0;
  int checks = 0;

  // Reference model: pc, captured byte, and whether the next enabled edge performs a capture.
  int   m_pc;
  int   m_instr;
  int   m_oprnd;
  bit   m_valid;
  bit   m_phase;
  bit   m_armed;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_fetch_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_addr (load_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pc        (pc),
    .instr     (instr),
    .oprnd     (oprnd),
    .phase     (phase),
    .valid     (valid)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input int la);
    if (r) begin
      m_pc = 0; m_instr = 0; m_oprnd = 0; m_valid = 0; m_phase = 0; m_armed = 0;
    end else if (l) begin
      m_pc = la; m_valid = 0; m_phase = 0; m_armed = e;
    end else if (!e) begin
      m_phase = 0; m_armed = 0;
    end else if (m_armed) begin
      m_instr = rom[m_pc] / 16;
      m_oprnd = rom[m_pc] % 16;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 4096;
      m_phase = 1;
      m_armed = 0;
    end else begin
      m_phase = 0; m_armed = 1;
    end
  endtask

  // Apply inputs for one cycle, advance the model with them, then compare every output.
  task automatic cycle(input bit r, input bit e, input bit l, input int la);
    reset = r; en = e; load = l; load_addr = 12'(la);
    @(posedge clk);
    model_edge(r, e, l, la);
    #1;
    check("pc",       int'(pc),       m_pc);
    check("rom_addr", int'(rom_addr), m_pc);
    check("instr",    int'(instr),    m_instr);
    check("oprnd",    int'(oprnd),    m_oprnd);
    check("valid",    int'(valid),    int'(m_valid));
    check("phase",    int'(phase),    int'(m_phase));
  endtask

  initial begin
    int ra;
    bit rr, re, rl;

    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h3A;
    rom[12'h001] = 8'h5C;
    rom[12'h100] = 8'h71;
    rom[12'hFFF] = 8'hE2;
    reset = 1'b1; en = 1'b0; load = 1'b0; load_addr = '0;
    m_pc = 0; m_instr = 0; m_oprnd = 0; m_valid = 0; m_phase = 0; m_armed = 0;

    // Reset then run
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("rst_pc", int'(pc), 0);
    check("rst_valid", int'(valid), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("run1_instr", int'(instr), 4'h3);
    check("run1_oprnd", int'(oprnd), 4'hA);
    check("run1_pc", int'(pc), 1);
    check("run1_phase", int'(phase), 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("run2_instr", int'(instr), 4'h5);
    check("run2_oprnd", int'(oprnd), 4'hC);
    check("run2_pc", int'(pc), 2);

    // Jump
    cycle(0, 1, 1, 12'h100);
    check("jmp_pc", int'(pc), 12'h100);
    check("jmp_valid", int'(valid), 0);
    cycle(0, 1, 0, 0);
    check("jmp_instr", int'(instr), 4'h7);
    check("jmp_oprnd", int'(oprnd), 4'h1);
    check("jmp_valid1", int'(valid), 1);
    check("jmp_pc1", int'(pc), 12'h101);

    // Wrap-around
    cycle(0, 1, 1, 12'hFFF);
    cycle(0, 1, 0, 0);
    check("wrap_instr", int'(instr), 4'hE);
    check("wrap_oprnd", int'(oprnd), 4'h2);
    check("wrap_pc", int'(pc), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("wrap2_instr", int'(instr), 4'h3);
    check("wrap2_oprnd", int'(oprnd), 4'hA);

    // Pause during EXEC for 3 cycles, then resume
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    check("pause_pc", int'(pc), 1);
    check("pause_instr", int'(instr), 4'h3);
    check("pause_phase", int'(phase), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("resume_instr", int'(instr), 4'h5);
    check("resume_pc", int'(pc), 2);

    // Load coinciding with a FETCH capture at pc=0x100
    cycle(0, 1, 1, 12'h100);
    cycle(0, 1, 1, 12'h001);
    check("lvc_pc", int'(pc), 1);
    check("lvc_valid", int'(valid), 0);
    check("lvc_instr", int'(instr), 4'h5);
    cycle(0, 1, 0, 0);
    check("lvc_cap", int'(instr), 4'h5);

    // Reset mid-operation in FETCH with en=1
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("mrst_pc", int'(pc), 0);
    check("mrst_instr", int'(instr), 0);
    check("mrst_phase", int'(phase), 0);

    // Randomized traffic over a randomized ROM image
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      re = ($urandom_range(0, 9) < 8);
      rl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0: ra = 12'hFFF;
        1: ra = 12'hFFE;
        2: ra = 0;
        default: ra = int'($urandom_range(0, 4095));
      endcase
      cycle(rr, re, rl, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
